divider: RTL and testbench
==========================

# divider

Sequential radix-2 restoring divider, the inverse of the team's combinational multiplier. It divides a 2·INPUT_SIZE-bit dividend by an INPUT_SIZE-bit divisor and returns a full-width quotient and remainder. One quotient bit is produced per clock, and operands and results are exchanged over a start/ready/done handshake. It sits beside the multiplier in the arithmetic datapath, for example to check that a product divided by one of its operands recovers the other.

## Interface
- INPUT_SIZE, 160, divisor width; the dividend and quotient are 2·INPUT_SIZE bits wide.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only while ready=1.
- dividend  input  2·INPUT_SIZE  numerator; captured when start is accepted.
- divisor  input  INPUT_SIZE  denominator; captured when start is accepted.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse when the results become valid.
- quotient  output  2·INPUT_SIZE  unsigned quotient.
- remainder  output  INPUT_SIZE  unsigned remainder.
- div_by_zero  output  1  set with done when the divisor was 0.

## Operation
- States:
  - IDLE: ready=1.
  - RUN: one quotient bit per edge.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Start accept: in IDLE with start=1, capture both operands.
  - divisor≠0: go to RUN and load the bit counter with 2·INPUT_SIZE.
  - divisor=0: go directly to DONE.
- RUN iteration, per edge:
  - Shift the partial remainder left by one, bringing in the next dividend bit MSB-first.
  - Trial-subtract the divisor from the (INPUT_SIZE+1)-bit partial remainder.
  - Non-negative result: keep it and shift 1 into the quotient. Negative result: restore the old value and shift 0 into the quotient.
  - Decrement the counter. When the counter reaches 0, go to DONE.
- Arithmetic: unsigned only. The partial remainder is INPUT_SIZE+1 bits, so the trial subtract cannot lose the carry. Quotient overflow is impossible because the quotient width equals the dividend width.
- Divide by zero:
  - quotient = all ones.
  - remainder = dividend[INPUT_SIZE-1:0].
  - div_by_zero=1.
- Holding results: quotient, remainder and div_by_zero update only on the edge that enters DONE. They hold until the next accepted start completes.
- start while not IDLE (RUN or DONE) is ignored. There is no queueing, and operand changes during RUN have no effect.

## Timing
- Reset (asynchronous, any state, including mid-RUN): state=IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0. Any in-flight operation is discarded.
- Normal latency: start accepted at edge k → state=DONE and done=1 after edge k+2·INPUT_SIZE. ready returns high after edge k+2·INPUT_SIZE+1.
- Divide-by-zero latency: done=1 after edge k. ready returns high after edge k+1.
- Throughput: the minimum spacing between accepted starts is 2·INPUT_SIZE+2 edges, or 2 edges for divide by zero.
- ready and done are never high in the same cycle.
- Results are valid in the done cycle and stable afterwards until the next done.

## Structure
- Shared package divider_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the localparams for dividend/quotient width (2·INPUT_SIZE) and counter width ($clog2(2·INPUT_SIZE+1)).
- Sub-module divider_step: purely combinational single iteration.
  - Inputs: partial remainder, incoming dividend bit, divisor.
  - Outputs: next partial remainder and quotient bit.
- The top level holds the FSM, the counter, the shift registers and the output registers.

## Test plan
All scenarios use INPUT_SIZE=8.
- Basic divide: dividend=1000, divisor=7, start at edge k → done after edge k+16, quotient=142, remainder=6, div_by_zero=0.
- Divide by one: dividend=65535, divisor=1 → quotient=65535, remainder=0, done after 16 edges.
- Divisor larger than dividend: dividend=5, divisor=200 → quotient=0, remainder=5.
- Divide by zero: dividend=100, divisor=0 → done after 1 edge, quotient=16'hFFFF, remainder=100, div_by_zero=1, ready high on the following cycle.
- Start while busy: start 1000/7, then pulse start with 9/3 at edge k+5 and during DONE → both ignored; the result is still 142 r 6, and a new start is accepted only once ready=1.
- Reset mid-operation: assert rst_n=0 at edge k+8 of a run → ready=1, done=0, quotient=0, remainder=0 immediately. A subsequent start of 255/16 gives quotient=15, remainder=15.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and width helpers for the sequential restoring divider.
// Widths are functions of INPUT_SIZE so every instance derives its own sizes.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_INPUT_SIZE = 160;

  // Width of the dividend and the quotient.
  function automatic int dividend_width(input int in_size);
    return 2 * in_size;
  endfunction

  // The bit counter has to hold the full iteration count 2*INPUT_SIZE.
  function automatic int counter_width(input int in_size);
    return $clog2(2 * in_size + 1);
  endfunction

  localparam int DEFAULT_DIVIDEND_W = dividend_width(DEFAULT_INPUT_SIZE);
  localparam int DEFAULT_CNT_W      = counter_width(DEFAULT_INPUT_SIZE);

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract,
// then keep or restore. Purely combinational.
module divider_step #(
  parameter int INPUT_SIZE = 8
) (
  input  logic [INPUT_SIZE:0]   i_rem,
  input  logic                  i_bit,
  input  logic [INPUT_SIZE-1:0] i_divisor,
  output logic [INPUT_SIZE:0]   o_rem,
  output logic                  o_qbit
);

  logic [INPUT_SIZE+1:0] w_shift;
  logic [INPUT_SIZE+1:0] w_diff;

  // One spare bit above the shifted remainder turns the borrow into a sign bit.
  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {2'b00, i_divisor};
  assign o_qbit  = ~w_diff[INPUT_SIZE+1];
  assign o_rem   = o_qbit ? w_diff[INPUT_SIZE:0] : w_shift[INPUT_SIZE:0];

endmodule

// File: rtl/divider.sv
// Sequential radix-2 restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock, start/ready/done handshake.
module divider
  import divider_pkg::*;
#(
  parameter int INPUT_SIZE = DEFAULT_INPUT_SIZE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [2*INPUT_SIZE-1:0]   dividend,
  input  logic [INPUT_SIZE-1:0]     divisor,
  output logic                      ready,
  output logic                      done,
  output logic [2*INPUT_SIZE-1:0]   quotient,
  output logic [INPUT_SIZE-1:0]     remainder,
  output logic                      div_by_zero
);

  localparam int DW = dividend_width(INPUT_SIZE);
  localparam int CW = counter_width(INPUT_SIZE);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [DW-1:0]         r_work;
  logic [INPUT_SIZE:0]   r_rem;
  logic [INPUT_SIZE-1:0] r_divisor;
  logic                  r_ready;
  logic                  r_done;
  logic [DW-1:0]         r_quot;
  logic [INPUT_SIZE-1:0] r_remainder;
  logic                  r_dbz;

  logic [INPUT_SIZE:0]   w_rem_next;
  logic                  w_qbit;
  logic [DW-1:0]         w_work_next;

  divider_step #(
    .INPUT_SIZE (INPUT_SIZE)
  ) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_work[DW-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  // r_work starts as the dividend; its MSBs feed the step while quotient bits
  // fill in from the LSB, so after 2N shifts it holds the quotient.
  assign w_work_next = {r_work[DW-2:0], w_qbit};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the block order does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_work      <= '0;
      r_rem       <= '0;
      r_divisor   <= '0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_quot      <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_work    <= dividend;
            r_divisor <= divisor;
            r_rem     <= '0;
            r_ready   <= 1'b0;
            if (divisor == '0) begin
              r_quot      <= '1;
              r_remainder <= dividend[INPUT_SIZE-1:0];
              r_dbz       <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_cnt   <= CNT_LOAD;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_work <= w_work_next;
          r_rem  <= w_rem_next;
          r_cnt  <= r_cnt - CNT_LAST;
          if (r_cnt == CNT_LAST) begin
            r_quot      <= w_work_next;
            r_remainder <= w_rem_next[INPUT_SIZE-1:0];
            r_dbz       <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready       = r_ready;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider with INPUT_SIZE=8: the driver pushes the
// hand-computed result per accepted start, the monitor pops on every done.
module tb_divider;

  localparam int N  = 8;
  localparam int DW = 2 * N;

  typedef struct {
    logic [DW-1:0] q;
    logic [N-1:0]  r;
    logic          dbz;
    int            acc;
    int            lat;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] dividend;
  logic [N-1:0]  divisor;
  logic          ready;
  logic          done;
  logic [DW-1:0] quotient;
  logic [N-1:0]  remainder;
  logic          div_by_zero;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   overlap_seen = 1'b0;

  divider #(.INPUT_SIZE(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && ready && done) overlap_seen = 1'b1;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        check("quotient",    32'(quotient),    32'(mon_e.q));
        check("remainder",   32'(remainder),   32'(mon_e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
        check("done_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
    end
  end

  // Waits at negedges until ready is high, bounded.
  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  // Called at a negedge with ready high; the following posedge accepts.
  task automatic issue(input logic [DW-1:0] dvd, input logic [N-1:0] dvs,
                       input bit push, input logic [DW-1:0] eq,
                       input logic [N-1:0] er, input logic edbz,
                       output int acc);
    exp_t e;
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    acc      = cyc + 1;
    if (push) begin
      e.q   = eq;
      e.r   = er;
      e.dbz = edbz;
      e.acc = acc;
      e.lat = edbz ? 0 : DW;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [DW-1:0] dvd,
                        input logic [N-1:0] dvs, input logic [DW-1:0] eq,
                        input logic [N-1:0] er, input logic edbz);
    int acc;
    wait_ready();
    issue(dvd, dvs, 1'b1, eq, er, edbz, acc);
    wait_ready();
    check({name, "_ready_return"}, 32'(cyc - acc), 32'((edbz ? 0 : DW) + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int acc;
    int n;
    rst_n    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2 rst_n = 1'b0;
    #2;
    check("reset_ready",     32'(ready),       32'd1);
    check("reset_done",      32'(done),        32'd0);
    check("reset_quotient",  32'(quotient),    32'd0);
    check("reset_remainder", 32'(remainder),   32'd0);
    check("reset_dbz",       32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("basic",     16'd1000,  8'd7,   16'd142,   8'd6,   1'b0);
    run_op("div_one",   16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0);
    run_op("big_dvs",   16'd5,     8'd200, 16'd0,     8'd5,   1'b0);
    run_op("div_zero",  16'd100,   8'd0,   16'hFFFF,  8'd100, 1'b1);
    run_op("after_dbz", 16'd12345, 8'd100, 16'd123,   8'd45,  1'b0);
    run_op("max_255",   16'd65535, 8'd255, 16'd257,   8'd0,   1'b0);
    run_op("div_two",   16'd65535, 8'd2,   16'd32767, 8'd1,   1'b0);
    run_op("zero_dvd",  16'd0,     8'd9,   16'd0,     8'd0,   1'b0);
    run_op("dbz_upper", 16'hAB12,  8'd0,   16'hFFFF,  8'h12,  1'b1);

    // Start while busy: pulses during RUN and during DONE must be ignored.
    wait_ready();
    issue(16'd1000, 8'd7, 1'b1, 16'd142, 8'd6, 1'b0, acc);
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'd9; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_done_seen", 32'(done), 32'd1);
    start = 1'b1; dividend = 16'd9; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    wait_ready();
    check("busy_ready_return", 32'(cyc - acc), 32'(DW + 1));
    repeat (3) @(negedge clk);
    check("busy_not_accepted", 32'(ready),     32'd1);
    check("hold_quotient",     32'(quotient),  32'd142);
    check("hold_remainder",    32'(remainder), 32'd6);

    // Asynchronous reset in the middle of a run discards the operation.
    issue(16'd1000, 8'd7, 1'b0, '0, '0, 1'b0, acc);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready",     32'(ready),       32'd1);
    check("midrst_done",      32'(done),        32'd0);
    check("midrst_quotient",  32'(quotient),    32'd0);
    check("midrst_remainder", 32'(remainder),   32'd0);
    check("midrst_dbz",       32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_reset", 16'd255, 8'd16, 16'd15, 8'd15, 1'b0);

    repeat (20) @(negedge clk);
    check("sb_drained",           32'(sb.size()),   32'd0);
    check("ready_done_exclusive", 32'(overlap_seen), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
